// File: rtl/cirno9_tm_pkg.sv
// rtl/cirno9_tm_pkg.sv - shared types and constants for the cirno9 end-of-test monitor
// Purpose : FSM state encoding, riscv-tests pass marker and default tohost PC.
// Ports   : none (package).
package cirno9_tm_pkg;

   typedef enum logic [1:0] {
      TM_IDLE = 2'd0,
      TM_RUN  = 2'd1,
      TM_DONE = 2'd2
   } tm_state_e;

   // riscv-tests leave gp==1 on success, (testnum<<1)|1 on failure.
   localparam int          RISCV_PASS_GP     = 1;
   localparam logic [31:0] TOHOST_PC_DEFAULT = 32'h8000_003c;

endpackage

// File: rtl/cirno9_hart_watch.sv
// rtl/cirno9_hart_watch.sv - per-hart tohost detector with sticky halt flag and gp latch
// Purpose : counts consecutive valid retire samples at TOHOST_PC; after STABLE_CYCLES
//           the hart is halted and that cycle's gp is captured.
// Ports   : clk_i, rst_i        clock, async active-high reset
//           clear_i             clear all state (monitor entering RUN)
//           run_i               monitor is in RUN; samples are ignored otherwise
//           pc_vld_i/pc_i/gp_i  retire strobe, PC and x3 of this hart
//           halted_o            registered halt flag
//           halted_d_o, gp_d_o  next-state halt flag / latched gp (same-edge verdict)
module cirno9_hart_watch
   import cirno9_tm_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter logic [XLEN-1:0] TOHOST_PC     = XLEN'(TOHOST_PC_DEFAULT),
   parameter int              STABLE_CYCLES = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            run_i,
   input  logic            pc_vld_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] gp_i,
   output logic            halted_o,
   output logic            halted_d_o,
   output logic [XLEN-1:0] gp_d_o
);

   localparam int SW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

   logic [SW-1:0]   cnt_q, cnt_d;
   logic            halted_q, halted_d;
   logic [XLEN-1:0] gp_q, gp_d;

   always_comb begin
      cnt_d    = cnt_q;
      halted_d = halted_q;
      gp_d     = gp_q;
      if (clear_i) begin
         cnt_d    = '0;
         halted_d = 1'b0;
         gp_d     = '0;
      end else if (run_i && !halted_q && pc_vld_i) begin
         if (pc_i == TOHOST_PC) begin
            // Final stable sample: halt and capture gp on this very edge.
            if (cnt_q == SW'(STABLE_CYCLES - 1)) begin
               halted_d = 1'b1;
               gp_d     = gp_i;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         halted_q <= 1'b0;
         gp_q     <= '0;
      end else begin
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
         gp_q     <= gp_d;
      end
   end

   assign halted_o   = halted_q;
   assign halted_d_o = halted_d;
   assign gp_d_o     = gp_d;

endmodule

// File: rtl/cirno9_test_monitor.sv
// rtl/cirno9_test_monitor.sv - end-of-test monitor for cirno9 riscv-tests regressions
// Purpose : watches NUM_HARTS cores for the tohost PC, latches gp at halt, applies a
//           programmable cycle timeout and produces one registered pass/fail verdict.
// Ports   : clk_i, rst_i        clock, async active-high reset
//           start_i             pulse: clear verdict, begin monitoring (ignored in RUN)
//           timeout_lim_i       cycle limit, 0 disables
//           hart_pc_vld_i       per-hart retire strobe
//           hart_pc_i/hart_gp_i per-hart PC / x3, hart i at [i*XLEN +: XLEN]
//           busy_o              in RUN
//           done_o              verdict valid, held until start/reset
//           pass_o, timed_out_o verdict
//           fail_hart_o         lowest failing hart (0 on pass)
//           fail_testnum_o      that hart's gp>>1
//           halted_o            per-hart halt flags
//           cycle_count_o       RUN cycles since start, saturating
module cirno9_test_monitor
   import cirno9_tm_pkg::*;
#(
   parameter int              NUM_HARTS     = 1,
   parameter int              XLEN          = 32,
   parameter logic [XLEN-1:0] TOHOST_PC     = XLEN'(TOHOST_PC_DEFAULT),
   parameter int              STABLE_CYCLES = 2,
   parameter int              CNT_W         = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [CNT_W-1:0]            timeout_lim_i,
   input  logic [NUM_HARTS-1:0]        hart_pc_vld_i,
   input  logic [NUM_HARTS*XLEN-1:0]   hart_pc_i,
   input  logic [NUM_HARTS*XLEN-1:0]   hart_gp_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        pass_o,
   output logic                        timed_out_o,
   output logic [$clog2(NUM_HARTS):0]  fail_hart_o,
   output logic [XLEN-2:0]             fail_testnum_o,
   output logic [NUM_HARTS-1:0]        halted_o,
   output logic [CNT_W-1:0]            cycle_count_o
);

   localparam int FHW = $clog2(NUM_HARTS) + 1;

   tm_state_e                state_q;
   logic [CNT_W-1:0]         cycle_count_q;
   logic                     done_q, pass_q, timed_out_q;
   logic [FHW-1:0]           fail_hart_q;
   logic [XLEN-2:0]          fail_testnum_q;

   logic                     enter_run;
   logic                     in_run;
   logic [NUM_HARTS-1:0]     halted_q, halted_d;
   logic [NUM_HARTS*XLEN-1:0] gp_d;

   assign in_run    = (state_q == TM_RUN);
   assign enter_run = start_i && !in_run;

   for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
      cirno9_hart_watch #(
         .XLEN          (XLEN),
         .TOHOST_PC     (TOHOST_PC),
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_watch (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clear_i    (enter_run),
         .run_i      (in_run),
         .pc_vld_i   (hart_pc_vld_i[g]),
         .pc_i       (hart_pc_i[g*XLEN +: XLEN]),
         .gp_i       (hart_gp_i[g*XLEN +: XLEN]),
         .halted_o   (halted_q[g]),
         .halted_d_o (halted_d[g]),
         .gp_d_o     (gp_d[g*XLEN +: XLEN])
      );
   end

   // Verdict is computed from next-state halt/gp so it can be registered on the
   // same edge that completes the final halt.
   logic                all_halted_d;
   logic                pass_d;
   logic                found;
   logic [FHW-1:0]      fail_idx_d;
   logic [XLEN-2:0]     fail_num_d;
   logic                timeout_hit;

   always_comb begin
      all_halted_d = &halted_d;
      found        = 1'b0;
      fail_idx_d   = '0;
      fail_num_d   = '0;
      for (int i = 0; i < NUM_HARTS; i++) begin
         if (!found && (!halted_d[i] || gp_d[i*XLEN +: XLEN] != XLEN'(RISCV_PASS_GP))) begin
            found      = 1'b1;
            fail_idx_d = FHW'(i);
            fail_num_d = halted_d[i] ? gp_d[i*XLEN + 1 +: XLEN - 1] : '0;
         end
      end
      pass_d = all_halted_d && !found;
   end

   assign timeout_hit = (timeout_lim_i != '0) &&
                        (cycle_count_q == timeout_lim_i - CNT_W'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= TM_IDLE;
         cycle_count_q  <= '0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         timed_out_q    <= 1'b0;
         fail_hart_q    <= '0;
         fail_testnum_q <= '0;
      end else begin
         case (state_q)
            TM_IDLE, TM_DONE: begin
               if (start_i) begin
                  state_q        <= TM_RUN;
                  cycle_count_q  <= '0;
                  done_q         <= 1'b0;
                  pass_q         <= 1'b0;
                  timed_out_q    <= 1'b0;
                  fail_hart_q    <= '0;
                  fail_testnum_q <= '0;
               end
            end
            TM_RUN: begin
               if (cycle_count_q != '1) begin
                  cycle_count_q <= cycle_count_q + CNT_W'(1);
               end
               // A halt completing on the timeout cycle takes priority.
               if (all_halted_d) begin
                  state_q        <= TM_DONE;
                  done_q         <= 1'b1;
                  pass_q         <= pass_d;
                  timed_out_q    <= 1'b0;
                  fail_hart_q    <= fail_idx_d;
                  fail_testnum_q <= fail_num_d;
               end else if (timeout_hit) begin
                  state_q        <= TM_DONE;
                  done_q         <= 1'b1;
                  pass_q         <= 1'b0;
                  timed_out_q    <= 1'b1;
                  fail_hart_q    <= fail_idx_d;
                  fail_testnum_q <= fail_num_d;
               end
            end
            default: state_q <= TM_IDLE;
         endcase
      end
   end

   assign busy_o         = in_run;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign timed_out_o    = timed_out_q;
   assign fail_hart_o    = fail_hart_q;
   assign fail_testnum_o = fail_testnum_q;
   assign halted_o       = halted_q;
   assign cycle_count_o  = cycle_count_q;

endmodule

// File: tb/tb_cirno9_test_monitor.sv
// tb/tb_cirno9_test_monitor.sv - scoreboard bench for cirno9_test_monitor (1-hart and 4-hart instances)
module tb_cirno9_test_monitor;

   localparam logic [31:0] TOHOST = 32'h8000_003c;

   typedef struct {
      logic        pass;
      logic        to;
      logic [2:0]  fhart;
      logic [30:0] fnum;
      logic [3:0]  halted;
      logic [31:0] cc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start1, start4;
   logic [31:0] tlim;
   logic        vld1;
   logic [31:0] pc1, gp1;
   logic [3:0]  vld4;
   logic [127:0] pc4, gp4;

   logic        busy1, done1, pass1, to1;
   logic [0:0]  fh1, hl1;
   logic [30:0] fn1;
   logic [31:0] cc1;
   logic        busy4, done4, pass4, to4;
   logic [2:0]  fh4;
   logic [3:0]  hl4;
   logic [30:0] fn4;
   logic [31:0] cc4;

   cirno9_test_monitor #(.NUM_HARTS(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .timeout_lim_i(tlim),
      .hart_pc_vld_i(vld1), .hart_pc_i(pc1), .hart_gp_i(gp1),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1), .timed_out_o(to1),
      .fail_hart_o(fh1), .fail_testnum_o(fn1), .halted_o(hl1), .cycle_count_o(cc1)
   );

   cirno9_test_monitor #(.NUM_HARTS(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .timeout_lim_i(tlim),
      .hart_pc_vld_i(vld4), .hart_pc_i(pc4), .hart_gp_i(gp4),
      .busy_o(busy4), .done_o(done4), .pass_o(pass4), .timed_out_o(to4),
      .fail_hart_o(fh4), .fail_testnum_o(fn4), .halted_o(hl4), .cycle_count_o(cc4)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q1[$];
   exp_t q4[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic p, input logic t, input logic [2:0] fh,
                               input logic [30:0] fn, input logic [3:0] h, input logic [31:0] cc);
      exp_t e;
      e.pass = p; e.to = t; e.fhart = fh; e.fnum = fn; e.halted = h; e.cc = cc;
      return e;
   endfunction

   task automatic cmp(input string tag, input exp_t e, input logic p, input logic t,
                      input logic [2:0] fh, input logic [30:0] fn, input logic [3:0] h,
                      input logic [31:0] cc);
      chk({tag, ".pass"},         64'(p),  64'(e.pass));
      chk({tag, ".timed_out"},    64'(t),  64'(e.to));
      chk({tag, ".fail_hart"},    64'(fh), 64'(e.fhart));
      chk({tag, ".fail_testnum"}, 64'(fn), 64'(e.fnum));
      chk({tag, ".halted"},       64'(h),  64'(e.halted));
      chk({tag, ".cycle_count"},  64'(cc), 64'(e.cc));
   endtask

   // Monitor: pops an expected verdict each time done rises.
   logic done1_prev = 1'b0;
   logic done4_prev = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (done1 && !done1_prev) begin
            if (q1.size() == 0) chk("dut1.unexpected_done", 64'd1, 64'd0);
            else cmp("dut1", q1.pop_front(), pass1, to1, {2'b0, fh1}, fn1, {3'b0, hl1}, cc1);
         end
         if (done4 && !done4_prev) begin
            if (q4.size() == 0) chk("dut4.unexpected_done", 64'd1, 64'd0);
            else cmp("dut4", q4.pop_front(), pass4, to4, fh4, fn4, hl4, cc4);
         end
         done1_prev = done1;
         done4_prev = done4;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sb(input string name);
      for (int k = 0; k < 200; k++) begin
         if (q1.size() == 0 && q4.size() == 0) break;
         tick();
      end
      chk({name, ".sb_drain"}, 64'(q1.size() + q4.size()), 64'd0);
      q1.delete();
      q4.delete();
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; start4 = 1'b0; tlim = '0;
      vld1 = 1'b0; pc1 = '0; gp1 = '0;
      vld4 = '0; pc4 = '0; gp4 = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst.done1",  64'(done1), 64'd0);
      chk("rst.busy1",  64'(busy1), 64'd0);
      chk("rst.cc1",    64'(cc1),   64'd0);
      chk("rst.done4",  64'(done4), 64'd0);
      chk("rst.pass4",  64'(pass4), 64'd0);
      chk("rst.halted4", 64'(hl4),  64'd0);

      // T1: halt after 50 idle cycles, gp=1
      q1.push_back(mk(1'b1, 1'b0, 3'd0, 31'd0, 4'h1, 32'd52));
      start1 = 1'b1; tick(); start1 = 1'b0;
      chk("t1.busy", 64'(busy1), 64'd1);
      repeat (50) tick();
      vld1 = 1'b1; pc1 = TOHOST; gp1 = 32'd1;
      tick(); tick();
      vld1 = 1'b0; pc1 = '0; gp1 = 32'hdead;
      wait_sb("t1");

      // T2: gp=7 -> fail testnum 3; start from DONE clears done
      q1.push_back(mk(1'b0, 1'b0, 3'd0, 31'd3, 4'h1, 32'd2));
      start1 = 1'b1; tick(); start1 = 1'b0;
      chk("t2.done_cleared", 64'(done1), 64'd0);
      vld1 = 1'b1; pc1 = TOHOST; gp1 = 32'd7;
      tick(); tick();
      vld1 = 1'b0; gp1 = 32'hdead;
      wait_sb("t2");

      // T3: timeout at 100
      tlim = 32'd100;
      q1.push_back(mk(1'b0, 1'b1, 3'd0, 31'd0, 4'h0, 32'd100));
      start1 = 1'b1; tick(); start1 = 1'b0;
      vld1 = 1'b1; pc1 = 32'h8000_0000;
      repeat (110) tick();
      vld1 = 1'b0;
      wait_sb("t3");
      tlim = '0;

      // T5: other PC resets the run, vld gaps hold the count
      q1.push_back(mk(1'b1, 1'b0, 3'd0, 31'd0, 4'h1, 32'd6));
      start1 = 1'b1; tick(); start1 = 1'b0;
      gp1 = 32'd1;
      vld1 = 1'b1; pc1 = TOHOST;        tick();
      vld1 = 1'b1; pc1 = 32'h8000_0040; tick();
      vld1 = 1'b1; pc1 = TOHOST;        tick();
      chk("t5.not_halted", 64'(hl1), 64'd0);
      vld1 = 1'b0; tick(); tick();
      chk("t5.gap_not_halted", 64'(hl1), 64'd0);
      vld1 = 1'b1; pc1 = TOHOST;        tick();
      vld1 = 1'b0;
      wait_sb("t5");

      // T6: final halt on the timeout cycle -> halt wins
      tlim = 32'd10;
      q1.push_back(mk(1'b1, 1'b0, 3'd0, 31'd0, 4'h1, 32'd10));
      start1 = 1'b1; tick(); start1 = 1'b0;
      repeat (8) tick();
      vld1 = 1'b1; pc1 = TOHOST; gp1 = 32'd1;
      tick(); tick();
      vld1 = 1'b0;
      wait_sb("t6");
      tlim = '0;

      // T4: 4 harts halt at 10,20,30,40 with gp 1,1,5,1
      q4.push_back(mk(1'b0, 1'b0, 3'd2, 31'd2, 4'hf, 32'd40));
      start4 = 1'b1; tick(); start4 = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         for (int h = 0; h < 4; h++) begin
            vld4[h] = 1'b1;
            if (t == 10 * (h + 1) - 1 || t == 10 * (h + 1)) begin
               pc4[h*32 +: 32] = TOHOST;
               gp4[h*32 +: 32] = (h == 2) ? 32'd5 : 32'd1;
            end else begin
               pc4[h*32 +: 32] = 32'h8000_1000 + 32'(t * 4);
               gp4[h*32 +: 32] = 32'h0bad;
            end
         end
         tick();
      end
      vld4 = '0;
      wait_sb("t4");

      // T7: reset mid-RUN, then clean restart; a second start cycle in RUN is ignored
      start4 = 1'b1; tick(); start4 = 1'b0;
      vld4 = 4'b0001; pc4 = {4{TOHOST}}; gp4 = {4{32'd1}};
      tick(); tick(); tick();
      chk("t7.hart0_halted", 64'(hl4), 64'h1);
      rst = 1'b1;
      #1;
      chk("t7.rst.busy",   64'(busy4), 64'd0);
      chk("t7.rst.done",   64'(done4), 64'd0);
      chk("t7.rst.halted", 64'(hl4),   64'd0);
      chk("t7.rst.cc",     64'(cc4),   64'd0);
      chk("t7.rst.fhart",  64'({to4, pass4, fh4, fn4}), 64'd0);
      vld4 = '0;
      tick();
      rst = 1'b0;
      tick();
      q4.push_back(mk(1'b1, 1'b0, 3'd0, 31'd0, 4'hf, 32'd2));
      vld4 = 4'hf;
      start4 = 1'b1; tick();
      tick(); start4 = 1'b0;
      tick();
      vld4 = '0;
      wait_sb("t7");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
